// File: rtl/adam_periph_uart_pkg.sv
// Shared UART peripheral definitions: rx FSM states and the parity helper also used by the TX.
package adam_periph_uart_pkg;

  localparam int unsigned SHIFT_W = 16;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Expected parity bit; bits above the frame length must be zero.
  function automatic logic parity_bit(input logic [SHIFT_W-1:0] bits, input logic odd);
    return (^bits) ^ odd;
  endfunction

endpackage

// File: rtl/adam_periph_uart_rx_sync.sv
// Two-flop synchroniser for the rx pin plus a falling-edge detect on the synchronised value.
module adam_periph_uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall_c
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Resets to the idle (high) line level so no edge is seen out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s   = sync_q;
  assign fall_c = prev_q & ~sync_q;

endmodule

// File: rtl/adam_periph_uart_rx.sv
// UART receiver: oversampled frame recovery with a valid/ready word port, error flags and pause handshake.
module adam_periph_uart_rx
  import adam_periph_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause_req,
  output logic                  pause_ack,
  input  logic                  parity_select,
  input  logic                  parity_control,
  input  logic [3:0]            data_length,
  input  logic                  stop_bits,
  input  logic [DATA_WIDTH-1:0] baud_rate,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  overrun
);

  typedef logic [DATA_WIDTH-1:0] data_t;

  rx_state_t          state_q, state_d;
  data_t              clk_count_q, clk_count_d;
  logic [3:0]         bit_count_q, bit_count_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               par_err_q, par_err_d;
  logic               frm_err_q, frm_err_d;
  logic               done_q, done_d;

  data_t data_d;
  logic  data_valid_d;
  logic  parity_error_d;
  logic  frame_error_d;
  logic  overrun_d;
  logic  pause_ack_d;

  logic rx_s;
  logic fall_c;
  logic half_hit_c;
  logic full_hit_c;

  adam_periph_uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .rx_s   (rx_s),
    .fall_c (fall_c)
  );

  assign half_hit_c = (clk_count_q == (baud_rate >> 1));
  assign full_hit_c = (clk_count_q == baud_rate);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RX_IDLE;
      clk_count_q  <= '0;
      bit_count_q  <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      done_q       <= 1'b0;
      data         <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
      pause_ack    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_count_q  <= clk_count_d;
      bit_count_q  <= bit_count_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      frm_err_q    <= frm_err_d;
      done_q       <= done_d;
      data         <= data_d;
      data_valid   <= data_valid_d;
      parity_error <= parity_error_d;
      frame_error  <= frame_error_d;
      overrun      <= overrun_d;
      pause_ack    <= pause_ack_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    clk_count_d    = clk_count_q + data_t'(1);
    bit_count_d    = bit_count_q;
    shift_d        = shift_q;
    par_err_d      = par_err_q;
    frm_err_d      = frm_err_q;
    done_d         = 1'b0;
    data_d         = data;
    data_valid_d   = data_valid;
    parity_error_d = parity_error;
    frame_error_d  = frame_error;
    overrun_d      = 1'b0;
    pause_ack_d    = 1'b0;

    // Frame recovery: every sample clears clk_count.
    case (state_q)
      RX_IDLE: begin
        clk_count_d = '0;
        if (fall_c && !pause_ack) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (half_hit_c) begin
          clk_count_d = '0;
          bit_count_d = '0;
          shift_d     = '0;
          par_err_d   = 1'b0;
          frm_err_d   = 1'b0;
          state_d     = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (full_hit_c) begin
          clk_count_d          = '0;
          shift_d[bit_count_q] = rx_s;
          if (bit_count_q == data_length - 4'd1) begin
            bit_count_d = '0;
            state_d     = parity_control ? RX_PARITY : RX_STOP;
          end else begin
            bit_count_d = bit_count_q + 4'd1;
          end
        end
      end
      RX_PARITY: begin
        if (full_hit_c) begin
          clk_count_d = '0;
          par_err_d   = (rx_s != parity_bit(shift_q, parity_select));
          state_d     = RX_STOP;
        end
      end
      RX_STOP: begin
        if (full_hit_c) begin
          clk_count_d = '0;
          if (!rx_s) begin
            frm_err_d = 1'b1;
          end
          // Returning to IDLE on the sample itself lets a back-to-back start edge be caught.
          if (bit_count_q == {3'b000, stop_bits}) begin
            state_d = RX_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_count_d = bit_count_q + 4'd1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // Word delivery; a completed frame that cannot be stored is dropped as an overrun.
    if (done_q) begin
      if (data_valid && !data_ready) begin
        overrun_d = 1'b1;
      end else begin
        data_d         = data_t'(shift_q);
        parity_error_d = par_err_q;
        frame_error_d  = frm_err_q;
        data_valid_d   = 1'b1;
      end
    end else if (data_valid && data_ready) begin
      data_valid_d = 1'b0;
    end

    // Grant only with the FSM idle and the last frame's word already delivered.
    pause_ack_d = pause_req && (state_d == RX_IDLE) && !done_d;
  end

endmodule

// File: tb/tb_adam_periph_uart_rx.sv
// Bench for adam_periph_uart_rx: directed frame table, randomized frames against a frame-level model,
// and hand sequences for glitch, overrun, pause and reset.
module tb_adam_periph_uart_rx;

  typedef struct {
    int unsigned baud;
    int unsigned len;
    bit          par_en;
    bit          odd;
    bit          sb;
    logic [15:0] d;
    bit          flip;
    bit [1:0]    stop_val;
    logic [31:0] exp_data;
    bit          exp_pe;
    bit          exp_fe;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        pe;
    logic        fe;
  } rec_t;

  logic        clk;
  logic        rst;
  logic        pause_req;
  logic        pause_ack;
  logic        parity_select;
  logic        parity_control;
  logic [3:0]  data_length;
  logic        stop_bits;
  logic [31:0] baud_rate;
  logic        rx;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready;
  logic        parity_error;
  logic        frame_error;
  logic        overrun;

  int tests = 0;
  int fails = 0;
  int unsigned valid_cycles = 0;
  int unsigned ovr_cnt = 0;
  rec_t cap_q[$];
  vec_t vecs[7];

  adam_periph_uart_rx #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .pause_req      (pause_req),
    .pause_ack      (pause_ack),
    .parity_select  (parity_select),
    .parity_control (parity_control),
    .data_length    (data_length),
    .stop_bits      (stop_bits),
    .baud_rate      (baud_rate),
    .rx             (rx),
    .data           (data),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .parity_error   (parity_error),
    .frame_error    (frame_error),
    .overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture accepted words and count valid/overrun cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (data_valid && data_ready) cap_q.push_back('{data, parity_error, frame_error});
      if (data_valid) valid_cycles <= valid_cycles + 1;
      if (overrun) ovr_cnt <= ovr_cnt + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold_bit(input logic b, input int unsigned p);
    rx = b;
    repeat (p) tick();
  endtask

  // Serialise one frame; the parity bit is the correct one unless flip is set.
  task automatic send_frame(input logic [15:0] d, input int unsigned len, input bit par_en,
                            input bit odd, input bit flip, input bit sb, input bit [1:0] stop_val,
                            input int unsigned p);
    logic [15:0] m;
    logic        pb;
    m  = d & 16'((32'd1 << len) - 32'd1);
    pb = (($countones(m) % 2) == 1) ^ odd ^ flip;
    hold_bit(1'b0, p);
    for (int i = 0; i < int'(len); i++) hold_bit(d[i], p);
    if (par_en) hold_bit(pb, p);
    hold_bit(stop_val[0], p);
    if (sb) hold_bit(stop_val[1], p);
    rx = 1'b1;
  endtask

  task automatic set_config(input int unsigned b, input int unsigned len, input bit pc,
                            input bit odd, input bit sb);
    int n;
    n = 0;
    pause_req = 1'b1;
    while (!pause_ack && n < 1000) begin
      tick();
      n++;
    end
    check("cfg_pause_ack", 32'(pause_ack), 32'd1);
    baud_rate      = b;
    data_length    = 4'(len);
    parity_control = pc;
    parity_select  = odd;
    stop_bits      = sb;
    tick();
    pause_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_word(input string name, input int unsigned limit, output rec_t r);
    int unsigned n;
    n = 0;
    while (cap_q.size() == 0 && n < limit) begin
      tick();
      n++;
    end
    check({name, "_arrived"}, 32'(cap_q.size() != 0), 32'd1);
    if (cap_q.size() != 0) r = cap_q.pop_front();
    else r = '{default: '0};
  endtask

  initial begin
    rec_t        r;
    int unsigned v0;
    int unsigned o0;
    bit          got;
    bit          early;

    vecs[0] = '{15, 8,  0, 0, 0, 16'h00A5, 0, 2'b11, 32'h0000_00A5, 0, 0};
    vecs[1] = '{15, 7,  1, 0, 0, 16'h0055, 1, 2'b11, 32'h0000_0055, 1, 0};
    vecs[2] = '{15, 7,  1, 1, 0, 16'h0055, 0, 2'b11, 32'h0000_0055, 0, 0};
    vecs[3] = '{15, 8,  0, 0, 1, 16'h0096, 0, 2'b01, 32'h0000_0096, 0, 1};
    vecs[4] = '{15, 8,  0, 0, 0, 16'h0000, 0, 2'b00, 32'h0000_0000, 0, 1};
    vecs[5] = '{7,  15, 1, 1, 1, 16'h5A3C, 0, 2'b11, 32'h0000_5A3C, 0, 0};
    vecs[6] = '{3,  1,  1, 0, 0, 16'h0001, 0, 2'b11, 32'h0000_0001, 0, 0};

    rst = 1'b0; rx = 1'b1; pause_req = 1'b0; data_ready = 1'b1;
    parity_select = 1'b0; parity_control = 1'b0; data_length = 4'd8; stop_bits = 1'b0;
    baud_rate = 32'd15;
    repeat (3) tick();
    check("rst_data", data, 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_pe", 32'(parity_error), 32'd0);
    check("rst_fe", 32'(frame_error), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_ack", 32'(pause_ack), 32'd0);
    rst = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < 7; i++) begin
      set_config(vecs[i].baud, vecs[i].len, vecs[i].par_en, vecs[i].odd, vecs[i].sb);
      send_frame(vecs[i].d, vecs[i].len, vecs[i].par_en, vecs[i].odd, vecs[i].flip, vecs[i].sb,
                 vecs[i].stop_val, vecs[i].baud + 1);
      wait_word($sformatf("vec%0d", i), 8 * vecs[i].baud + 20, r);
      check($sformatf("vec%0d_data", i), r.d, vecs[i].exp_data);
      check($sformatf("vec%0d_pe", i), 32'(r.pe), 32'(vecs[i].exp_pe));
      check($sformatf("vec%0d_fe", i), 32'(r.fe), 32'(vecs[i].exp_fe));
      repeat (4) tick();
    end

    for (int k = 0; k < 25; k++) begin
      int unsigned b;
      int unsigned len;
      bit          pen;
      bit          odd;
      bit          sb;
      bit          flip;
      bit [1:0]    sv;
      logic [15:0] d;
      logic [31:0] ed;
      bit          epe;
      bit          efe;
      b    = $urandom_range(12, 3);
      len  = $urandom_range(15, 1);
      pen  = 1'($urandom_range(1, 0));
      odd  = 1'($urandom_range(1, 0));
      sb   = 1'($urandom_range(1, 0));
      flip = ($urandom_range(3, 0) == 0);
      sv[0] = ($urandom_range(3, 0) != 0);
      sv[1] = ($urandom_range(3, 0) != 0);
      d    = 16'($urandom);
      ed   = 32'(d) & ((32'd1 << len) - 32'd1);
      epe  = pen && flip;
      efe  = !sv[0] || (sb && !sv[1]);
      set_config(b, len, pen, odd, sb);
      send_frame(d, len, pen, odd, flip, sb, sv, b + 1);
      wait_word($sformatf("rnd%0d", k), 8 * b + 20, r);
      check($sformatf("rnd%0d_data", k), r.d, ed);
      check($sformatf("rnd%0d_pe", k), 32'(r.pe), 32'(epe));
      check($sformatf("rnd%0d_fe", k), 32'(r.fe), 32'(efe));
      repeat ($urandom_range(5, 1)) tick();
    end

    // Glitch shorter than half a bit must not produce a word.
    set_config(15, 8, 0, 0, 0);
    v0 = valid_cycles;
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (60) tick();
    check("glitch_no_valid", valid_cycles - v0, 32'd0);
    send_frame(16'h3C, 8, 0, 0, 0, 0, 2'b11, 16);
    wait_word("after_glitch", 200, r);
    check("after_glitch_data", r.d, 32'h3C);

    // Overrun: second word dropped while the first is held.
    repeat (10) tick();
    data_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(16'h11, 8, 0, 0, 0, 0, 2'b11, 16);
    repeat (5) tick();
    send_frame(16'h22, 8, 0, 0, 0, 0, 2'b11, 16);
    repeat (20) tick();
    check("ovr_data_kept", data, 32'h11);
    check("ovr_valid", 32'(data_valid), 32'd1);
    check("ovr_pulses", ovr_cnt - o0, 32'd1);
    // Accept in the delivery cycle: start edge to delivery edge is 4 + 7 + 9*16 = 155 edges.
    o0 = ovr_cnt;
    fork
      send_frame(16'h22, 8, 0, 0, 0, 0, 2'b11, 16);
      begin
        repeat (155) tick();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
      end
    join
    repeat (5) tick();
    check("same_cycle_no_ovr", ovr_cnt - o0, 32'd0);
    check("same_cycle_data", data, 32'h22);
    check("same_cycle_valid", 32'(data_valid), 32'd1);
    wait_word("same_cycle_old", 4, r);
    check("same_cycle_old_data", r.d, 32'h11);
    data_ready = 1'b1;
    wait_word("same_cycle_new", 10, r);
    check("same_cycle_new_data", r.d, 32'h22);
    repeat (5) tick();

    // Pause requested mid-frame is granted no earlier than that frame's word.
    got = 1'b0;
    early = 1'b0;
    fork
      send_frame(16'h5A, 8, 0, 0, 0, 0, 2'b11, 16);
      begin
        repeat (40) tick();
        pause_req = 1'b1;
        for (int n = 0; n < 400 && !pause_ack; n++) begin
          tick();
          if (data_valid) got = 1'b1;
          if (pause_ack && !got) early = 1'b1;
        end
      end
    join
    check("pause_not_early", 32'(early), 32'd0);
    check("pause_granted", 32'(pause_ack), 32'd1);
    check("pause_word_seen", 32'(got), 32'd1);
    wait_word("pause_frame", 10, r);
    check("pause_frame_data", r.d, 32'h5A);
    v0 = valid_cycles;
    send_frame(16'h77, 8, 0, 0, 0, 0, 2'b11, 16);
    repeat (40) tick();
    check("paused_ignored", valid_cycles - v0, 32'd0);
    check("paused_queue", 32'(cap_q.size()), 32'd0);
    check("paused_ack_held", 32'(pause_ack), 32'd1);
    baud_rate = 32'd7;
    tick();
    pause_req = 1'b0;
    repeat (3) tick();
    check("unpause_ack", 32'(pause_ack), 32'd0);
    send_frame(16'hC3, 8, 0, 0, 0, 0, 2'b11, 8);
    wait_word("baud7", 100, r);
    check("baud7_data", r.d, 32'hC3);
    check("baud7_fe", 32'(r.fe), 32'd0);

    // Reset in the middle of a frame clears every output, including a pending word.
    repeat (5) tick();
    data_ready = 1'b0;
    send_frame(16'h81, 8, 0, 0, 0, 0, 2'b11, 8);
    repeat (10) tick();
    check("pre_rst_valid", 32'(data_valid), 32'd1);
    hold_bit(1'b0, 8);
    hold_bit(1'b1, 8);
    hold_bit(1'b0, 4);
    rst = 1'b0;
    tick();
    tick();
    check("midrst_data", data, 32'd0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    check("midrst_pe", 32'(parity_error), 32'd0);
    check("midrst_fe", 32'(frame_error), 32'd0);
    check("midrst_ovr", 32'(overrun), 32'd0);
    check("midrst_ack", 32'(pause_ack), 32'd0);
    rst = 1'b1;
    rx = 1'b1;
    repeat (200) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
